// File: rtl/l3_port_arbiter.sv
// Round-robin arbiter sharing the single L3 port among the per-processor L2 FSMs.
// One transaction (fill or write-back) in flight; completion is routed back to the winner only.
module l3_port_arbiter #(
    parameter int NUM_L2                 = 4,
    parameter int ADDRESS_WIDTH          = 32,
    parameter int MAIN_MEMORY_DATA_WIDTH = 128
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_L2-1:0]                        l2_read_req,
    input  logic [NUM_L2-1:0]                        l2_wb_req,
    input  logic [NUM_L2*ADDRESS_WIDTH-1:0]          l2_addr,
    input  logic [NUM_L2*MAIN_MEMORY_DATA_WIDTH-1:0] l2_wb_data,
    output logic [NUM_L2-1:0]                        l2_L3_ready,
    output logic [NUM_L2-1:0]                        l2_wb_verified,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]        write_data_to_L2_from_L3_out,
    output logic                                     read_from_L3_request,
    output logic                                     write_back_to_L3_request,
    output logic [ADDRESS_WIDTH-1:0]                 cache_L3_memory_address,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]        write_back_to_L3_data,
    input  logic                                     L3_ready,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]        write_data_to_L2_from_L3,
    input  logic                                     write_back_to_L3_verified,
    output logic [1:0]                               grant_id,
    output logic                                     arbiter_busy,
    output logic [1:0]                               state_dbg
);

    // L2 side: a requester holds read/wb level until it sees its own completion pulse.
    // L3 side: the request level stays high until the matching completion input is sampled.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t     state, next_state;
    logic [1:0] rr_ptr;
    logic       op_wb;

    logic [3:0] req_vec, wb_vec;
    logic [1:0] scan_idx, win_idx;
    logic       win_found, win_wb, completion;
    logic [3:0] grant_onehot;

    logic              issue_wb, l3_active_d, finish;
    logic              read_req_d, wb_req_d, busy_d;
    logic [NUM_L2-1:0] ready_d, verified_d;

    assign state_dbg = state;

    // Widened to 4 bits so the 2-bit index works for every legal NUM_L2.
    always_comb begin
        req_vec = '0;
        wb_vec  = '0;
        req_vec[NUM_L2-1:0] = l2_read_req | l2_wb_req;
        wb_vec[NUM_L2-1:0]  = l2_wb_req;
    end

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NUM_L2; k++) begin
            scan_idx = 2'((int'(rr_ptr) + k) % NUM_L2);
            if (!win_found && req_vec[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign win_wb       = wb_vec[win_idx];
    assign completion   = op_wb ? write_back_to_L3_verified : L3_ready;
    assign grant_onehot = 4'b0001 << grant_id;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (win_found) next_state = S_ISSUE;
            S_ISSUE:   next_state = S_WAIT;
            S_WAIT:    if (completion) next_state = S_RELEASE;
            // Wait for the winner to drop its level so a stale request is not re-granted.
            S_RELEASE: if (!req_vec[grant_id]) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        issue_wb    = (state == S_IDLE) ? win_wb : op_wb;
        l3_active_d = (next_state == S_ISSUE) || (next_state == S_WAIT);
        read_req_d  = l3_active_d && !issue_wb;
        wb_req_d    = l3_active_d && issue_wb;
        finish      = (state == S_WAIT) && (next_state == S_RELEASE);
        ready_d     = (finish && !op_wb) ? grant_onehot[NUM_L2-1:0] : '0;
        verified_d  = (finish && op_wb) ? grant_onehot[NUM_L2-1:0] : '0;
        busy_d      = (next_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_from_L3_request         <= 1'b0;
            write_back_to_L3_request     <= 1'b0;
            l2_L3_ready                  <= '0;
            l2_wb_verified               <= '0;
            arbiter_busy                 <= 1'b0;
            grant_id                     <= 2'd0;
            cache_L3_memory_address      <= '0;
            write_back_to_L3_data        <= '0;
            write_data_to_L2_from_L3_out <= '0;
            op_wb                        <= 1'b0;
            rr_ptr                       <= 2'd0;
        end else begin
            read_from_L3_request     <= read_req_d;
            write_back_to_L3_request <= wb_req_d;
            l2_L3_ready              <= ready_d;
            l2_wb_verified           <= verified_d;
            arbiter_busy             <= busy_d;
            if (state == S_IDLE && win_found) begin
                grant_id                <= win_idx;
                cache_L3_memory_address <= l2_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                write_back_to_L3_data   <= l2_wb_data[int'(win_idx)*MAIN_MEMORY_DATA_WIDTH +: MAIN_MEMORY_DATA_WIDTH];
                op_wb                   <= win_wb;
            end
            if (finish && !op_wb) write_data_to_L2_from_L3_out <= write_data_to_L2_from_L3;
            if (state == S_RELEASE && next_state == S_IDLE)
                rr_ptr <= (int'(grant_id) == NUM_L2 - 1) ? 2'd0 : grant_id + 2'd1;
        end
    end

endmodule

// File: tb/tb_l3_port_arbiter.sv
// Directed bench for l3_port_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_l3_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      l2_read_req, l2_wb_req;
    logic [N*AW-1:0]   l2_addr;
    logic [N*DW-1:0]   l2_wb_data;
    logic [N-1:0]      l2_L3_ready, l2_wb_verified;
    logic [DW-1:0]     write_data_to_L2_from_L3_out;
    logic              read_from_L3_request, write_back_to_L3_request;
    logic [AW-1:0]     cache_L3_memory_address;
    logic [DW-1:0]     write_back_to_L3_data;
    logic              L3_ready;
    logic [DW-1:0]     write_data_to_L2_from_L3;
    logic              write_back_to_L3_verified;
    logic [1:0]        grant_id;
    logic              arbiter_busy;
    logic [1:0]        state_dbg;

    always #5 clk = ~clk;

    l3_port_arbiter #(.NUM_L2(N), .ADDRESS_WIDTH(AW), .MAIN_MEMORY_DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset(reset),
        .l2_read_req(l2_read_req),
        .l2_wb_req(l2_wb_req),
        .l2_addr(l2_addr),
        .l2_wb_data(l2_wb_data),
        .l2_L3_ready(l2_L3_ready),
        .l2_wb_verified(l2_wb_verified),
        .write_data_to_L2_from_L3_out(write_data_to_L2_from_L3_out),
        .read_from_L3_request(read_from_L3_request),
        .write_back_to_L3_request(write_back_to_L3_request),
        .cache_L3_memory_address(cache_L3_memory_address),
        .write_back_to_L3_data(write_back_to_L3_data),
        .L3_ready(L3_ready),
        .write_data_to_L2_from_L3(write_data_to_L2_from_L3),
        .write_back_to_L3_verified(write_back_to_L3_verified),
        .grant_id(grant_id),
        .arbiter_busy(arbiter_busy),
        .state_dbg(state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record (owner, op, address, data, age, done).
    logic          m_valid = 1'b0;
    logic          m_busy, m_done, m_pulse, m_op_wb;
    logic [1:0]    m_gid, m_ptr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_fill;
    int            m_age;
    int            model_grants[$];
    int            dut_grants[$];

    always @(posedge clk) begin
        logic [3:0] req;
        logic [1:0] cand;
        logic       found;
        req = 4'(l2_read_req | l2_wb_req);
        if (reset) begin
            m_valid = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_pulse = 1'b0; m_op_wb = 1'b0;
            m_gid = 2'd0; m_ptr = 2'd0; m_addr = '0; m_data = '0; m_fill = '0; m_age = 0;
        end else if (m_valid) begin
            m_pulse = 1'b0;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    cand = 2'((int'(m_ptr) + k) % N);
                    if (!found && req[cand]) begin
                        found   = 1'b1;
                        m_gid   = cand;
                        m_op_wb = l2_wb_req[cand];
                        m_addr  = l2_addr[int'(cand)*AW +: AW];
                        m_data  = l2_wb_data[int'(cand)*DW +: DW];
                    end
                end
                if (found) begin
                    m_busy = 1'b1; m_done = 1'b0; m_age = 0;
                    model_grants.push_back(int'(m_gid));
                end
            end else if (!m_done) begin
                // The first cycle after the grant is the issue cycle; completions count afterwards.
                if (m_age >= 1 && (m_op_wb ? write_back_to_L3_verified : L3_ready)) begin
                    m_done  = 1'b1;
                    m_pulse = 1'b1;
                    if (!m_op_wb) m_fill = write_data_to_L2_from_L3;
                end
                m_age++;
            end else if (!req[m_gid]) begin
                m_busy = 1'b0;
                m_done = 1'b0;
                m_ptr  = 2'((int'(m_gid) + 1) % N);
            end
        end
    end

    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        logic         exp_rd, exp_wb;
        logic [N-1:0] onehot;
        if (m_valid) begin
            exp_rd = m_busy && !m_done && !m_op_wb;
            exp_wb = m_busy && !m_done && m_op_wb;
            onehot = N'(1) << m_gid;
            check("read_req", read_from_L3_request, exp_rd);
            check("wb_req", write_back_to_L3_request, exp_wb);
            check("l2_ready", l2_L3_ready, (m_pulse && !m_op_wb) ? onehot : '0);
            check("l2_verified", l2_wb_verified, (m_pulse && m_op_wb) ? onehot : '0);
            check("busy", arbiter_busy, m_busy);
            check("grant_id", grant_id, m_gid);
            if (exp_rd || exp_wb) check("l3_addr", cache_L3_memory_address, m_addr);
            if (exp_wb) check("l3_wb_data", write_back_to_L3_data, m_data);
            if (m_pulse && !m_op_wb) check("fill_data", write_data_to_L2_from_L3_out, m_fill);
            if (arbiter_busy && !prev_busy) dut_grants.push_back(int'(grant_id));
            prev_busy = arbiter_busy;
        end
    end

    // Stimulus state: L3 responder and per-L2 auto-drop after the completion pulse.
    logic          resp_en = 1'b0;
    int            resp_lat = 3;
    int            resp_cnt = 0;
    logic [DW-1:0] resp_data = '0;
    logic          inj_rd = 1'b0, inj_wbv = 1'b0;
    int            hold_after[N];
    int            drop_timer[N];

    task automatic step();
        @(negedge clk);
        L3_ready = inj_rd;
        write_back_to_L3_verified = inj_wbv;
        write_data_to_L2_from_L3 = inj_rd ? resp_data : '0;
        if (resp_en && (read_from_L3_request || write_back_to_L3_request)) begin
            resp_cnt++;
            if (resp_cnt == resp_lat) begin
                if (read_from_L3_request) begin
                    L3_ready = 1'b1;
                    write_data_to_L2_from_L3 = resp_data;
                end else begin
                    write_back_to_L3_verified = 1'b1;
                end
            end
        end else begin
            resp_cnt = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (l2_L3_ready[i] || l2_wb_verified[i]) drop_timer[i] = hold_after[i];
            else if (drop_timer[i] > 0) drop_timer[i]--;
            if (drop_timer[i] == 0) begin
                l2_read_req[i] = 1'b0;
                l2_wb_req[i]   = 1'b0;
                drop_timer[i]  = -1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_read(input int i, input logic [AW-1:0] a);
        l2_addr[i*AW +: AW] = a;
        l2_read_req[i] = 1'b1;
    endtask

    task automatic drain(input string name);
        int   c = 0;
        logic timed_out;
        while ((arbiter_busy || (|(l2_read_req | l2_wb_req))) && c < 200) begin
            step();
            c++;
        end
        timed_out = (c >= 200);
        check(name, timed_out, 1'b0);
    endtask

    task automatic wait_pulse(output logic [N-1:0] rd, output logic [N-1:0] vf, output logic [DW-1:0] fill);
        int c = 0;
        rd = '0; vf = '0; fill = '0;
        while (c < 40) begin
            step();
            c++;
            if ((l2_L3_ready | l2_wb_verified) != '0) begin
                rd = l2_L3_ready; vf = l2_wb_verified; fill = write_data_to_L2_from_L3_out;
                break;
            end
        end
    endtask

    logic [N-1:0]  p_rd, p_vf;
    logic [DW-1:0] p_fill;
    logic          saw_rd;

    initial begin
        reset = 1'b1;
        l2_read_req = '0; l2_wb_req = '0; l2_addr = '0; l2_wb_data = '0;
        L3_ready = 1'b0; write_data_to_L2_from_L3 = '0; write_back_to_L3_verified = 1'b0;
        for (int i = 0; i < N; i++) begin hold_after[i] = 0; drop_timer[i] = -1; end

        // Reset values
        step(); step(); step();
        check("rst_rd", read_from_L3_request, 1'b0);
        check("rst_ready", l2_L3_ready, 4'b0000);
        check("rst_busy", arbiter_busy, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        reset = 1'b0;
        step();

        // 1: single read from L2 1
        resp_en = 1'b1; resp_lat = 3; resp_data = {16{8'hA5}};
        set_read(1, 32'h4000_0040);
        step();
        check("t1_rd_n1", read_from_L3_request, 1'b1);
        check("t1_gid", grant_id, 2'd1);
        check("t1_addr", cache_L3_memory_address, 32'h4000_0040);
        wait_pulse(p_rd, p_vf, p_fill);
        check("t1_ready", p_rd, 4'b0010);
        check("t1_fill", p_fill, {16{8'hA5}});
        step();
        check("t1_pulse_1cyc", l2_L3_ready, 4'b0000);
        drain("t1_drain");

        // 2: all four read at once from a fresh pointer
        do_reset();
        model_grants.delete(); dut_grants.delete();
        resp_data = {4{$urandom}};
        for (int i = 0; i < N; i++) set_read(i, 32'h1000_0000 + 32'(i * 64));
        drain("t2_drain");
        check("t2_dut_count", 32'(dut_grants.size()), 32'd4);
        check("t2_model_count", 32'(model_grants.size()), 32'd4);
        for (int i = 0; i < N; i++) begin
            if (i < dut_grants.size()) check("t2_dut_order", 32'(dut_grants[i]), 32'(i));
            if (i < model_grants.size()) check("t2_model_order", 32'(model_grants[i]), 32'(i));
        end
        set_read(3, 32'h3333_0000);
        set_read(0, 32'h0000_3330);
        step();
        check("t2_wrap_gid", grant_id, 2'd0);
        drain("t2_wrap_drain");

        // 3: L2 2 asserts write-back and read together
        l2_wb_data[2*DW +: DW] = 128'h1234;
        l2_addr[2*AW +: AW] = 32'h2222_0080;
        l2_wb_req[2] = 1'b1;
        l2_read_req[2] = 1'b1;
        step();
        check("t3_wb_req", write_back_to_L3_request, 1'b1);
        check("t3_wb_data", write_back_to_L3_data, 128'h1234);
        saw_rd = read_from_L3_request;
        p_vf = '0;
        for (int c = 0; c < 30 && p_vf == '0; c++) begin
            step();
            saw_rd |= read_from_L3_request;
            p_vf = l2_wb_verified;
        end
        check("t3_verified", p_vf, 4'b0100);
        check("t3_no_read", saw_rd, 1'b0);
        drain("t3_drain");

        // 4: spurious completions
        resp_en = 1'b0;
        inj_rd = 1'b1; resp_data = 128'hDEAD;
        step();
        inj_rd = 1'b0;
        step();
        check("t4_idle_ready", l2_L3_ready, 4'b0000);
        check("t4_idle_busy", arbiter_busy, 1'b0);
        check("t4_idle_state", state_dbg, 2'd0);
        set_read(3, 32'h4444_0000);
        repeat (4) step();
        inj_wbv = 1'b1;
        step();
        inj_wbv = 1'b0;
        step();
        check("t4_wrong_verified", l2_wb_verified, 4'b0000);
        check("t4_still_read", read_from_L3_request, 1'b1);
        check("t4_still_wait", state_dbg, 2'd2);
        resp_en = 1'b1;
        drain("t4_drain");

        // 5: reset in WAIT aborts; pointer returns to 0
        do_reset();
        set_read(1, 32'h5555_0010);
        drain("t5_pre_drain");
        resp_en = 1'b0;
        set_read(2, 32'h5555_0020);
        set_read(0, 32'h5555_0000);
        repeat (4) step();
        check("t5_gid_before", grant_id, 2'd2);
        reset = 1'b1;
        step();
        check("t5_rst_rd", read_from_L3_request, 1'b0);
        check("t5_rst_busy", arbiter_busy, 1'b0);
        check("t5_rst_addr", cache_L3_memory_address, 32'h0);
        check("t5_rst_state", state_dbg, 2'd0);
        reset = 1'b0;
        step();
        check("t5_regrant_gid", grant_id, 2'd0);
        check("t5_regrant_rd", read_from_L3_request, 1'b1);
        resp_en = 1'b1;
        drain("t5_drain");

        // 6: winner holds its request after its pulse
        do_reset();
        model_grants.delete(); dut_grants.delete();
        hold_after[1] = 3;
        set_read(1, 32'h6666_0010);
        set_read(2, 32'h6666_0020);
        wait_pulse(p_rd, p_vf, p_fill);
        check("t6_ready", p_rd, 4'b0010);
        for (int c = 0; c < 2; c++) begin
            step();
            check("t6_hold_busy", arbiter_busy, 1'b1);
            check("t6_hold_state", state_dbg, 2'd3);
            check("t6_hold_no_req", read_from_L3_request, 1'b0);
        end
        drain("t6_drain");
        hold_after[1] = 0;
        check("t6_dut_count", 32'(dut_grants.size()), 32'd2);
        check("t6_model_count", 32'(model_grants.size()), 32'd2);
        if (dut_grants.size() == 2) begin
            check("t6_dut_first", 32'(dut_grants[0]), 32'd1);
            check("t6_dut_second", 32'(dut_grants[1]), 32'd2);
        end
        if (model_grants.size() == 2) check("t6_model_second", 32'(model_grants[1]), 32'd2);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
